// File: rtl/uarch_pkg.sv
// rtl/uarch_pkg.sv - shared micro-architecture constants and fetch types
package uarch_pkg;

    localparam int CPU_ADDR_BITS      = 32;
    localparam int CPU_INST_BITS      = 32;
    localparam int FETCH_WIDTH        = 2;
    localparam int FETCH_MAX_INFLIGHT = 2;
    localparam int FETCH_PKT_BITS     = FETCH_WIDTH * CPU_INST_BITS;

    typedef logic [CPU_ADDR_BITS-1:0]  addr_t;
    typedef logic [FETCH_PKT_BITS-1:0] pkt_t;

    localparam addr_t BOOT_PC      = 32'h0000_0000;
    localparam addr_t FETCH_STRIDE = addr_t'(4 * FETCH_WIDTH);

    typedef struct packed {
        addr_t pc;
        pkt_t  data;
        logic  filled;
        logic  kill;
    } fetch_entry_t;

    // Sequential packet address; wraps naturally at the top of the address space.
    function automatic addr_t next_fetch_pc(input addr_t cur_pc);
        return cur_pc + FETCH_STRIDE;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - redirect, I-cache and inst buffer signals of the fetch unit
interface fetch_unit_if;
    import uarch_pkg::*;

    logic  redirect_val;
    addr_t redirect_pc;
    logic  icache_req_val;
    addr_t icache_req_addr;
    logic  icache_req_rdy;
    logic  icache_resp_val;
    pkt_t  icache_resp_data;
    addr_t pc;
    pkt_t  icache_dout;
    logic  icache_dout_val;
    logic  inst_buffer_rdy;

    modport master (
        input  redirect_val, redirect_pc,
        input  icache_req_rdy, icache_resp_val, icache_resp_data,
        input  inst_buffer_rdy,
        output icache_req_val, icache_req_addr,
        output pc, icache_dout, icache_dout_val
    );

    modport slave (
        output redirect_val, redirect_pc,
        output icache_req_rdy, icache_resp_val, icache_resp_data,
        output inst_buffer_rdy,
        input  icache_req_val, icache_req_addr,
        input  pc, icache_dout, icache_dout_val
    );

endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order storage for issued fetch packets with fill and kill tracking
module fetch_queue
    import uarch_pkg::*;
#(
    parameter int DEPTH = FETCH_MAX_INFLIGHT
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  alloc_i,
    input  addr_t alloc_pc_i,
    input  logic  fill_i,
    input  pkt_t  fill_data_i,
    input  logic  flush_i,
    input  logic  pop_i,
    output logic  full_o,
    output logic  head_filled_o,
    output logic  head_kill_o,
    output addr_t head_pc_o,
    output pkt_t  head_data_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    fetch_entry_t ent_q [DEPTH];
    fetch_entry_t ent_d [DEPTH];
    ptr_t         alloc_ptr_q, alloc_ptr_d;
    ptr_t         fill_ptr_q,  fill_ptr_d;
    ptr_t         head_ptr_q,  head_ptr_d;
    cnt_t         count_q,     count_d;
    logic [DEPTH-1:0] live;
    logic         fill_ok;

    // An entry is live when its distance from the head is below the occupancy.
    always_comb begin
        live = '0;
        for (int i = 0; i < DEPTH; i++) begin
            live[i] = cnt_t'(ptr_t'(ptr_t'(i) - head_ptr_q)) < count_q;
        end
    end

    assign fill_ok = live[fill_ptr_q] && !ent_q[fill_ptr_q].filled;

    always_comb begin
        ent_d       = ent_q;
        alloc_ptr_d = alloc_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        head_ptr_d  = head_ptr_q;
        count_d     = count_q + cnt_t'(alloc_i) - cnt_t'(pop_i);

        if (fill_i) begin
            ent_d[fill_ptr_q].data   = fill_data_i;
            ent_d[fill_ptr_q].filled = 1'b1;
            fill_ptr_d               = fill_ptr_q + ptr_t'(1);
        end

        if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (live[i]) begin
                    ent_d[i].kill = 1'b1;
                end
            end
        end

        if (pop_i) begin
            ent_d[head_ptr_q].filled = 1'b0;
            ent_d[head_ptr_q].kill   = 1'b0;
            head_ptr_d               = head_ptr_q + ptr_t'(1);
        end

        // Never collides with a flush: requests are withheld during a redirect.
        if (alloc_i) begin
            ent_d[alloc_ptr_q].pc     = alloc_pc_i;
            ent_d[alloc_ptr_q].data   = '0;
            ent_d[alloc_ptr_q].filled = 1'b0;
            ent_d[alloc_ptr_q].kill   = 1'b0;
            alloc_ptr_d               = alloc_ptr_q + ptr_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            head_ptr_q  <= '0;
            count_q     <= '0;
        end else begin
            ent_q       <= ent_d;
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            head_ptr_q  <= head_ptr_d;
            count_q     <= count_d;
        end
    end

    assign full_o        = count_q == cnt_t'(DEPTH);
    assign head_filled_o = ent_q[head_ptr_q].filled;
    assign head_kill_o   = ent_q[head_ptr_q].kill;
    assign head_pc_o     = ent_q[head_ptr_q].pc;
    assign head_data_o   = ent_q[head_ptr_q].data;

    resp_has_owner: assert property (@(posedge clk) disable iff (!rst) fill_i |-> fill_ok)
        else $error("fetch_queue: I-cache response with no outstanding request");

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch address generation and I-cache / inst buffer handshakes
module fetch_unit
    import uarch_pkg::*;
#(
    parameter int    MAX_INFLIGHT = FETCH_MAX_INFLIGHT,
    parameter addr_t RESET_PC     = BOOT_PC
) (
    input  logic  clk,
    input  logic  rst,
    fetch_unit_if.master bus
);

    addr_t fetch_pc_q, fetch_pc_d;
    logic  q_full;
    logic  head_filled;
    logic  head_kill;
    addr_t head_pc;
    pkt_t  head_data;
    logic  req_fire;
    logic  present;
    logic  pop;

    assign bus.icache_req_val  = !q_full && rst && !bus.redirect_val;
    assign bus.icache_req_addr = fetch_pc_q;
    assign req_fire            = bus.icache_req_val && bus.icache_req_rdy;

    // A redirect hides the head packet in the same cycle it becomes stale.
    assign present = rst && head_filled && !head_kill && !bus.redirect_val;
    assign pop     = head_filled && (head_kill || (present && bus.inst_buffer_rdy));

    assign bus.icache_dout_val = present;
    assign bus.pc              = present ? head_pc   : '0;
    assign bus.icache_dout     = present ? head_data : '0;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (bus.redirect_val) begin
            fetch_pc_d = bus.redirect_pc;
        end else if (req_fire) begin
            fetch_pc_d = next_fetch_pc(fetch_pc_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_queue #(
        .DEPTH (MAX_INFLIGHT)
    ) u_queue (
        .clk           (clk),
        .rst           (rst),
        .alloc_i       (req_fire),
        .alloc_pc_i    (fetch_pc_q),
        .fill_i        (bus.icache_resp_val),
        .fill_data_i   (bus.icache_resp_data),
        .flush_i       (bus.redirect_val),
        .pop_i         (pop),
        .full_o        (q_full),
        .head_filled_o (head_filled),
        .head_kill_o   (head_kill),
        .head_pc_o     (head_pc),
        .head_data_o   (head_data)
    );

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter MAX_INFLIGHT, default FETCH_MAX_INFLIGHT (2): maximum fetch packets issued but not yet delivered downstream; power of two, at least 2.
REQ-002 Parameter RESET_PC, default BOOT_PC (32'h0000_0000): fetch address after reset.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset; synchronous, active-low (0 = reset).
REQ-005 redirect_val  in  1  backend redirect (mispredict or exception); the same signal drives the inst buffer flush.
REQ-006 redirect_pc  in  CPU_ADDR_BITS  redirect target, 4-byte aligned.
REQ-007 icache_req_val  out  1  fetch request valid.
REQ-008 icache_req_addr  out  CPU_ADDR_BITS  fetch packet address.
REQ-009 icache_req_rdy  in  1  I-cache accepts request.
REQ-010 icache_resp_val  in  1  response valid; responses return in request order, untagged, with no backpressure.
REQ-011 icache_resp_data  in  FETCH_WIDTH*CPU_INST_BITS  packet; instruction 0 in the low bits.
REQ-012 pc  out  CPU_ADDR_BITS  packet PC to the inst buffer.
REQ-013 icache_dout  out  FETCH_WIDTH*CPU_INST_BITS  packet to the inst buffer.
REQ-014 icache_dout_val  out  1  packet valid to the inst buffer.
REQ-015 inst_buffer_rdy  in  1  inst buffer accepts the packet.

Function
REQ-016 Queue of MAX_INFLIGHT entries, each {pc, data, filled, kill}; alloc, fill and head pointers wrap modulo MAX_INFLIGHT, plus an occupancy count of width $clog2(MAX_INFLIGHT)+1.
REQ-017 icache_req_val = (occupancy < MAX_INFLIGHT) && rst && !redirect_val; icache_req_addr = fetch_pc.
REQ-018 On a request handshake: allocate an entry {pc=fetch_pc, filled=0, kill=0}; fetch_pc <= fetch_pc + 4*FETCH_WIDTH, modulo 2^CPU_ADDR_BITS.
REQ-019 icache_req_val and icache_req_addr hold stable while icache_req_rdy=0, unless a redirect occurs.
REQ-020 On icache_resp_val: write data to the entry at the fill pointer, set filled, and advance the fill pointer.
REQ-021 Entries are drained only from the head, and only when the head is filled.
REQ-022 Head filled and kill=1: pop in one cycle with no output.
REQ-023 Head filled and kill=0: icache_dout_val=1 with pc/icache_dout taken from that entry, suppressed while redirect_val=1; pop when icache_dout_val && inst_buffer_rdy.
REQ-024 When icache_dout_val=0, pc and icache_dout are '0.
REQ-025 On redirect_val: set kill on every allocated entry, including one filled in that same cycle; fetch_pc <= redirect_pc; no request that cycle; the first request to redirect_pc issues the next cycle.
REQ-026 Allocation, fill and pop may all occur in one cycle; occupancy changes by (alloc - pop).
REQ-027 Because occupancy bounds the requests outstanding at the I-cache, a response can never be lost.
REQ-028 A response with no unfilled allocated entry is a protocol error and is covered by an assertion.
REQ-029 Latency: a response arriving in cycle N with an empty queue ahead of it appears at icache_dout_val in cycle N+1.

Reset
REQ-030 With rst=0 at a rising edge: fetch_pc <= RESET_PC; all pointers and occupancy <= 0; all filled/kill bits <= 0.
REQ-031 While rst=0: icache_req_val=0 and icache_dout_val=0.
REQ-032 Reset mid-operation discards all in-flight entries, and responses already outstanding at the I-cache are not tracked. The I-cache is reset by the same rst.

Structure
REQ-033 FETCH_MAX_INFLIGHT and BOOT_PC go in uarch_pkg; CPU_ADDR_BITS, CPU_INST_BITS and FETCH_WIDTH are already there.
REQ-034 One sub-module, fetch_queue, holds the entry storage, pointers and kill logic; fetch_unit holds fetch_pc and the handshakes.

Verification
REQ-035 Reset then I-cache always ready with 1-cycle response latency, buffer always ready -> requests at 0x0, 0x8, 0x10; packets delivered in order with pc 0x0, 0x8, 0x10.
REQ-036 inst_buffer_rdy=0 held -> after 2 requests icache_req_val=0; release -> delivery resumes at pc 0x0 and no packet is lost.
REQ-037 Redirect to 0x100 with 2 unreturned requests -> both responses dropped, no icache_dout_val for them; next request address 0x100, first delivered pc 0x100.
REQ-038 Redirect in the same cycle as a response and as a head presentation -> icache_dout_val=0 that cycle; that packet is never delivered.
REQ-039 icache_req_rdy=0 for 5 cycles -> address held at 0x8; fetch_pc wrap at 0xFFFF_FFF8 -> next address 0x0.
REQ-040 rst=0 asserted mid-stream -> next cycle both valids are 0; after release the first request is to RESET_PC.
